// File: rtl/tt_pwm_bank.sv
// Bank of CH PWM channels sharing one prescaled edge/center-aligned counter.
// Active TOP and duties reload from shadows only at period boundaries.
module tt_pwm_bank #(
  parameter int CH = 4,
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          wr_en,
  input  logic [3:0]    addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [CH-1:0] pwm_out,
  output logic          period_tick
);

  logic [W-1:0]  duty_sh_q  [CH];
  logic [W-1:0]  duty_act_q [CH];
  logic [W-1:0]  top_sh_q;
  logic [W-1:0]  top_act_q;
  logic [W-1:0]  cnt_q;
  logic [W-1:0]  cnt_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] pre_q;
  logic [2:0]    ctrl_q;
  logic          down_q;
  logic          down_d;
  logic [CH-1:0] pwm_q;
  logic [CH-1:0] cmp;
  logic          ptick_q;
  logic [7:0]    rd_q;
  logic [7:0]    rd_d;

  logic en;
  logic center;
  logic inv;
  logic we;
  logic tick;
  logic bnd;
  logic ctrl_wr;

  assign en      = ctrl_q[0];
  assign center  = ctrl_q[1];
  assign inv     = ctrl_q[2];
  assign we      = wr_en & ena;
  assign tick    = en && (pre_q == presc_q);
  assign bnd     = tick && (cnt_d == '0);
  assign ctrl_wr = we && (addr == 4'hA);

  // Counter step; applied only on a prescaler tick.
  always_comb begin
    cnt_d  = cnt_q;
    down_d = down_q;
    if (!center) begin
      down_d = 1'b0;
      cnt_d  = (cnt_q >= top_act_q) ? '0 : cnt_q + 1'b1;
    end else if (!down_q) begin
      if (cnt_q >= top_act_q) begin
        cnt_d  = (top_act_q == '0) ? '0 : cnt_q - 1'b1;
        down_d = (cnt_d != '0);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d  = cnt_q - 1'b1;
      down_d = (cnt_q > 1);
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cmp[i] = cnt_q < duty_act_q[i];
    end
  end

  always_comb begin
    rd_d = '0;
    case (addr)
      4'h8: rd_d = 8'(top_sh_q);
      4'h9: rd_d = 8'(presc_q);
      4'hA: rd_d = {5'b0, ctrl_q};
      default: begin
        for (int i = 0; i < CH; i++) begin
          if (addr == 4'(i)) rd_d = 8'(duty_sh_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      top_sh_q  <= {W{1'b1}};
      top_act_q <= {W{1'b1}};
      cnt_q     <= '0;
      presc_q   <= '0;
      pre_q     <= '0;
      ctrl_q    <= '0;
      down_q    <= 1'b0;
      pwm_q     <= '0;
      ptick_q   <= 1'b0;
      rd_q      <= '0;
    end else if (ena) begin
      rd_q <= rd_d;
      if (!en) begin
        pre_q     <= '0;
        cnt_q     <= '0;
        down_q    <= 1'b0;
        top_act_q <= top_sh_q;
        for (int i = 0; i < CH; i++) duty_act_q[i] <= duty_sh_q[i];
        pwm_q     <= {CH{inv}};
        ptick_q   <= 1'b0;
      end else begin
        pre_q <= tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          cnt_q  <= cnt_d;
          down_q <= down_d;
        end
        if (bnd) begin
          top_act_q <= top_sh_q;
          for (int i = 0; i < CH; i++) duty_act_q[i] <= duty_sh_q[i];
        end
        ptick_q <= bnd;
        pwm_q   <= cmp ^ {CH{inv}};
      end
      // A CENTER flip resumes counting upward from the current value.
      if (ctrl_wr && (wr_data[1] != center)) down_q <= 1'b0;
      if (we) begin
        for (int i = 0; i < CH; i++) begin
          if (addr == 4'(i)) duty_sh_q[i] <= wr_data[W-1:0];
        end
        if (addr == 4'h8) top_sh_q <= wr_data[W-1:0];
        if (addr == 4'h9) presc_q <= wr_data[PW-1:0];
        if (addr == 4'hA) ctrl_q <= wr_data[2:0];
      end
    end
  end

  assign rd_data     = rd_q;
  assign pwm_out     = pwm_q;
  assign period_tick = ptick_q;

endmodule

// File: doc/tt_pwm_bank.md
TT_PWM_BANK -- requirements
Module: tt_pwm_bank

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of PWM channels (legal range 1..8).
REQ-002 SHALL have parameter W, default 8, meaning counter, period and duty width in bits (legal range 4..8).
REQ-003 SHALL have parameter PW, default 4, meaning prescaler width in bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ena  input  1  design enable; when low, all state holds and writes are ignored.
REQ-007 wr_en  input  1  register write strobe.
REQ-008 addr  input  4  register address for both write and readback.
REQ-009 wr_data  input  8  write data; W-bit and PW-bit registers take the low bits.
REQ-010 rd_data  output  8  registered readback of register[addr], zero-extended.
REQ-011 pwm_out  output  CH  registered PWM outputs, bit i = channel i.
REQ-012 period_tick  output  1  one-cycle pulse at each period boundary.

Function
REQ-013 Register map: 0x0-0x7 duty shadow ch0-7; 0x8 TOP shadow; 0x9 PRESC; 0xA CTRL (bit0 EN, bit1 CENTER, bit2 INV).
REQ-014 Writes are accepted when wr_en=1 and ena=1; writes to duty channels >= CH and to 0xB-0xF are ignored.
REQ-015 rd_data SHALL equal register[addr] one cycle after addr is presented; unmapped or unimplemented addresses read 0.
REQ-016 Prescaler counts 0..PRESC, then restarts at 0; a tick is asserted in the cycle it equals PRESC (PRESC=0 gives a tick every cycle).
REQ-017 Edge mode (CENTER=0): on each tick, the counter runs 0,1,..,TOP,0,...; the period is TOP+1 ticks.
REQ-018 Center mode (CENTER=1): on each tick, the counter runs 0,1,..,TOP,TOP-1,..,1,0,...; the period is 2*TOP ticks; with TOP=0 the counter stays at 0 and the period is 1 tick.
REQ-019 Period boundary = the tick on which the counter returns to 0; period_tick is high for exactly one clk after that update.
REQ-020 At a period boundary, the active TOP and all active duties SHALL load from their shadows in the same cycle.
REQ-021 If a shadow write coincides with a boundary, active registers take the pre-write shadow value; the new value applies from the next boundary.
REQ-022 pwm_out[i] SHALL equal (counter < duty_active[i]) XOR INV, registered, one cycle after the counter value.
REQ-023 duty=0 gives a constant INV level; duty > TOP gives a constant NOT INV level.
REQ-024 Compare, counter and TOP arithmetic SHALL be unsigned W-bit with no overflow past TOP.
REQ-025 EN=0: prescaler and counter are held at 0, direction is up, active registers copy their shadows every cycle, pwm_out = {CH{INV}}, period_tick=0.
REQ-026 The EN 0->1 transition starts the count at 0 on the next tick, using the current shadows.
REQ-027 A change to CENTER while running takes effect immediately; the counter continues from its current value, counting up.

Reset
REQ-028 rst=1 SHALL, at the next clk edge: set duties (shadow/active) to 0, TOP (shadow/active) to 2^W-1, PRESC/CTRL/prescaler/counter to 0, direction up, and pwm_out, period_tick and rd_data to 0.
REQ-029 rst SHALL override ena and wr_en, and SHALL be effective mid-period with no residual pulse.

Verification (CH=4, W=8, PW=4)
REQ-030 TOP=9, PRESC=0, duty0=3, CTRL=1 -> pwm_out[0] high for 3 of every 10 clk; period_tick every 10 clk.
REQ-031 CTRL=3, TOP=4, duty1=2 -> period 8 clk, pwm_out[1] high for 3 clk per period (counts 0,1,1); period_tick every 8 clk.
REQ-032 Edge mode, TOP=9, duty0=3 running; write duty0=7 at counter=5 -> 3-clk pulse completes, then 7-clk pulses start after the next period_tick.
REQ-033 duty2=0, duty3=255, TOP=9 -> pwm_out[2]=0 and pwm_out[3]=1 constant; setting INV=1 -> both invert.
REQ-034 PRESC=3, TOP=9 -> counter steps every 4 clk; period_tick every 40 clk.
REQ-035 rst pulsed mid-period -> next cycle pwm_out=0, period_tick=0; readback of 0x8=255, 0xA=0.
